// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: register map, reset values, address window mask and byte-lane helpers
// shared by the GPIO bank and its synchroniser.
package gpio_bank_pkg;

    typedef enum logic [5:0] {
        REG_OUT      = 6'h00,
        REG_OEB      = 6'h01,
        REG_IN       = 6'h02,
        REG_IRQ_EN   = 6'h03,
        REG_IRQ_STAT = 6'h04,
        REG_IRQ_POL  = 6'h05
    } reg_ofs_e;

    localparam logic [31:0] WIN_MASK     = 32'hFFFF_FF00;

    localparam logic [31:0] RST_OUT      = 32'h0000_0000;
    localparam logic [31:0] RST_OEB      = 32'hFFFF_FFFF;
    localparam logic [31:0] RST_IRQ_EN   = 32'h0000_0000;
    localparam logic [31:0] RST_IRQ_STAT = 32'h0000_0000;
    localparam logic [31:0] RST_IRQ_POL  = 32'h0000_0000;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                                input logic [31:0] wdat,
                                                input logic [3:0]  sel);
        logic [31:0] m;
        m = lane_mask(sel);
        return (cur & ~m) | (wdat & m);
    endfunction

endpackage

// File: rtl/gpio_bank_sync.sv
// gpio_bank_sync: 2-flop pad synchroniser plus a delayed copy for per-pin edge detection
// with selectable polarity (0 = rising, 1 = falling).
module gpio_bank_sync #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pad_in,
    input  logic [W-1:0] pol,
    output logic [W-1:0] sync_q,
    output logic [W-1:0] edge_det
);

    logic [W-1:0] meta_q;
    logic [W-1:0] dly_q;
    logic [2:0]   fill_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            dly_q  <= '0;
            fill_q <= '0;
        end else begin
            meta_q <= pad_in;
            sync_q <= meta_q;
            dly_q  <= sync_q;
            fill_q <= {fill_q[1:0], 1'b1};
        end
    end

    // Edges only count once sync and its delayed copy both hold real pad samples.
    assign edge_det = fill_q[2] ? ((sync_q & ~dly_q & ~pol) | (~sync_q & dly_q & pol)) : '0;

endmodule

// File: rtl/wb_gpio_bank.sv
// wb_gpio_bank: Wishbone-classic GPIO bank (OUT/OEB/IN, optional edge interrupts).
// Interrupt registers and irq exist only when GPIO_BANK_IRQ_EN is defined.
module wb_gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int          NPINS    = 16,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [NPINS-1:0] io_in,
    output logic [NPINS-1:0] io_out,
    output logic [NPINS-1:0] io_oeb,
    output logic             irq
);

    logic             in_window;
    logic             req;
    logic             wr;
    logic [5:0]       ofs;
    logic [31:0]      out_wr;
    logic [31:0]      oeb_wr;
    logic [31:0]      rdata;
    logic [NPINS-1:0] out_q;
    logic [NPINS-1:0] oeb_q;
    logic [NPINS-1:0] pin_sync;
    logic [NPINS-1:0] pin_edge;
    logic [NPINS-1:0] pol;

    assign in_window = (wbs_adr_i & WIN_MASK) == (BASE_ADR & WIN_MASK);
    assign req       = wbs_cyc_i & wbs_stb_i & in_window & ~wbs_ack_o;
    assign wr        = req & wbs_we_i;
    assign ofs       = wbs_adr_i[7:2];
    assign out_wr    = merge_lanes(32'(out_q), wbs_dat_i, wbs_sel_i);
    assign oeb_wr    = merge_lanes(32'(oeb_q), wbs_dat_i, wbs_sel_i);

    gpio_bank_sync #(.W(NPINS)) u_sync (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .pad_in   (io_in),
        .pol      (pol),
        .sync_q   (pin_sync),
        .edge_det (pin_edge)
    );

`ifdef GPIO_BANK_IRQ_EN
    logic [NPINS-1:0] irq_en_q;
    logic [NPINS-1:0] irq_stat_q;
    logic [NPINS-1:0] irq_pol_q;
    logic [31:0]      en_wr;
    logic [31:0]      pol_wr;
    logic [31:0]      clr_mask;
    logic             unused_bits;

    assign en_wr    = merge_lanes(32'(irq_en_q), wbs_dat_i, wbs_sel_i);
    assign pol_wr   = merge_lanes(32'(irq_pol_q), wbs_dat_i, wbs_sel_i);
    assign clr_mask = (wr && ofs == REG_IRQ_STAT) ? (wbs_dat_i & lane_mask(wbs_sel_i)) : '0;
    assign pol      = irq_pol_q;

    // A new edge in the same cycle as its W1C leaves the status bit set.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_en_q   <= RST_IRQ_EN[NPINS-1:0];
            irq_stat_q <= RST_IRQ_STAT[NPINS-1:0];
            irq_pol_q  <= RST_IRQ_POL[NPINS-1:0];
            irq        <= 1'b0;
        end else begin
            if (wr && ofs == REG_IRQ_EN)  irq_en_q  <= en_wr[NPINS-1:0];
            if (wr && ofs == REG_IRQ_POL) irq_pol_q <= pol_wr[NPINS-1:0];
            irq_stat_q <= (irq_stat_q & ~clr_mask[NPINS-1:0]) | pin_edge;
            irq        <= |(irq_stat_q & irq_en_q);
        end
    end

    assign unused_bits = ^{wbs_adr_i[1:0], out_wr, oeb_wr, en_wr, pol_wr, clr_mask};
`else
    logic unused_bits;

    assign pol         = '0;
    assign irq         = 1'b0;
    assign unused_bits = ^{wbs_adr_i[1:0], out_wr, oeb_wr, pin_edge};
`endif

    always_comb begin
        rdata = '0;
        case (ofs)
            REG_OUT:      rdata = 32'(out_q);
            REG_OEB:      rdata = 32'(oeb_q);
            REG_IN:       rdata = 32'(pin_sync);
`ifdef GPIO_BANK_IRQ_EN
            REG_IRQ_EN:   rdata = 32'(irq_en_q);
            REG_IRQ_STAT: rdata = 32'(irq_stat_q);
            REG_IRQ_POL:  rdata = 32'(irq_pol_q);
`endif
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_q     <= RST_OUT[NPINS-1:0];
            oeb_q     <= RST_OEB[NPINS-1:0];
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
            if (wr && ofs == REG_OUT) out_q <= out_wr[NPINS-1:0];
            if (wr && ofs == REG_OEB) oeb_q <= oeb_wr[NPINS-1:0];
        end
    end

    assign io_out = out_q;
    assign io_oeb = oeb_q;

endmodule

// File: tb/tb_wb_gpio_bank.sv
// tb_wb_gpio_bank: directed bench for wb_gpio_bank with a 16-pin bank and an 8-pin bank
// sharing one Wishbone bus; interrupt scenarios follow GPIO_BANK_IRQ_EN.
module tb_wb_gpio_bank;

    localparam logic [31:0] BASE16 = 32'h3000_0000;
    localparam logic [31:0] BASE8  = 32'h4000_0000;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        cyc    = 1'b0;
    logic        stb    = 1'b0;
    logic        we     = 1'b0;
    logic [3:0]  sel    = 4'h0;
    logic [31:0] adr    = 32'h0;
    logic [31:0] dat_w  = 32'h0;
    logic        ack16, ack8, irq16, irq8;
    logic [31:0] dat16, dat8;
    logic [15:0] io_in16 = 16'h0;
    logic [15:0] io_out16, io_oeb16;
    logic [7:0]  io_in8 = 8'h0;
    logic [7:0]  io_out8, io_oeb8;
    logic        bus_ack;
    logic [31:0] bus_dat;
    logic [31:0] rd;
    int          lat;
    int          n_checks = 0;
    int          n_fail   = 0;

    assign bus_ack = ack16 | ack8;
    assign bus_dat = dat16 | dat8;

    always #5 clk = ~clk;

    wb_gpio_bank #(.NPINS(16), .BASE_ADR(BASE16)) dut16 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack16),
        .wbs_dat_o(dat16), .io_in(io_in16), .io_out(io_out16), .io_oeb(io_oeb16), .irq(irq16)
    );

    wb_gpio_bank #(.NPINS(8), .BASE_ADR(BASE8)) dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack8),
        .wbs_dat_o(dat8), .io_in(io_in8), .io_out(io_out8), .io_oeb(io_oeb8), .irq(irq8)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns lat = edges until ack (0 = no ack within 8 cycles).
    task automatic wb_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic w, output logic [31:0] rdat, output int l);
        adr = a; dat_w = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        l = 0;
        rdat = '0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (bus_ack) begin
                l = i;
                rdat = bus_dat;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        n_checks++; if (io_out16 !== 16'h0000) begin n_fail++; $display("FAIL reset_io_out: got %h want %h", io_out16, 16'h0000); end
        n_checks++; if (io_oeb16 !== 16'hFFFF) begin n_fail++; $display("FAIL reset_io_oeb: got %h want %h", io_oeb16, 16'hFFFF); end
        n_checks++; if (io_oeb8 !== 8'hFF) begin n_fail++; $display("FAIL reset_io_oeb8: got %h want %h", io_oeb8, 8'hFF); end
        n_checks++; if (bus_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus_ack); end
        n_checks++; if (bus_dat !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", bus_dat); end
        n_checks++; if (irq16 !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq16); end
        rst = 1'b0;
        step(1);
        wb_xfer(BASE16 + 32'h04, 32'h0, 4'hF, 1'b0, rd, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL reset_oeb_read_lat: got %0d want 1", lat); end
        n_checks++; if (rd !== 32'h0000_FFFF) begin n_fail++; $display("FAIL reset_oeb_read: got %h want %h", rd, 32'h0000_FFFF); end
        step(1);
    endtask

    task automatic test_out_write();
        wb_xfer(BASE16, 32'h0000_A5A5, 4'b0001, 1'b1, rd, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL out_wr_lat: got %0d want 1", lat); end
        n_checks++; if (io_out16 !== 16'h00A5) begin n_fail++; $display("FAIL out_wr_lane0: got %h want %h", io_out16, 16'h00A5); end
        step(1);
        n_checks++; if (bus_ack !== 1'b0) begin n_fail++; $display("FAIL out_wr_single_pulse: got %b want 0", bus_ack); end
        wb_xfer(BASE16, 32'h1234_5678, 4'b0010, 1'b1, rd, lat);
        n_checks++; if (io_out16 !== 16'h56A5) begin n_fail++; $display("FAIL out_wr_lane1: got %h want %h", io_out16, 16'h56A5); end
        step(1);
        wb_xfer(BASE16, 32'h0, 4'hF, 1'b0, rd, lat);
        n_checks++; if (rd !== 32'h0000_56A5) begin n_fail++; $display("FAIL out_read: got %h want %h", rd, 32'h0000_56A5); end
        step(1);
        wb_xfer(BASE16 + 32'h04, 32'hFFFF_00F0, 4'b0011, 1'b1, rd, lat);
        n_checks++; if (io_oeb16 !== 16'h00F0) begin n_fail++; $display("FAIL oeb_wr: got %h want %h", io_oeb16, 16'h00F0); end
        step(1);
    endtask

    task automatic test_in_sync();
        io_in16 = 16'h0000;
        step(4);
        io_in16 = 16'h0001;
        step(1);
        wb_xfer(BASE16 + 32'h08, 32'h0, 4'hF, 1'b0, rd, lat);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL in_too_early: got %h want %h", rd, 32'h0); end
        step(4);
        wb_xfer(BASE16 + 32'h08, 32'h0, 4'hF, 1'b0, rd, lat);
        n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL in_settled: got %h want %h", rd, 32'h1); end
        step(1);
        io_in16 = 16'h0003;
        step(2);
        wb_xfer(BASE16 + 32'h08, 32'h0, 4'hF, 1'b0, rd, lat);
        n_checks++; if (rd !== 32'h3) begin n_fail++; $display("FAIL in_two_cycles: got %h want %h", rd, 32'h3); end
        step(1);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  pat;
        logic [31:0] dat_low;
        pat = '0;
        dat_low = 32'hDEAD_BEEF;
        adr = BASE16; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            pat[i] = bus_ack;
            if (i == 1) dat_low = bus_dat;
        end
        cyc = 1'b0; stb = 1'b0;
        n_checks++; if (pat !== 4'b0101) begin n_fail++; $display("FAIL held_stb_acks: got %b want %b", pat, 4'b0101); end
        n_checks++; if (dat_low !== 32'h0) begin n_fail++; $display("FAIL dat_when_no_ack: got %h want 0", dat_low); end
        step(1);
    endtask

    task automatic test_window();
        wb_xfer(BASE8, 32'hFFFF_FFFF, 4'hF, 1'b1, rd, lat);
        step(1);
        wb_xfer(BASE8, 32'h0, 4'hF, 1'b0, rd, lat);
        n_checks++; if (rd !== 32'h0000_00FF) begin n_fail++; $display("FAIL npins8_out_read: got %h want %h", rd, 32'h0000_00FF); end
        n_checks++; if (io_out8 !== 8'hFF) begin n_fail++; $display("FAIL npins8_io_out: got %h want %h", io_out8, 8'hFF); end
        step(1);
        wb_xfer(BASE8 + 32'h20, 32'h0, 4'hF, 1'b0, rd, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL unmapped_ack: got lat %0d want 1", lat); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h want 0", rd); end
        step(1);
        wb_xfer(BASE8 + 32'h20, 32'h0, 4'hF, 1'b1, rd, lat);
        step(1);
        wb_xfer(BASE8, 32'h0, 4'hF, 1'b0, rd, lat);
        n_checks++; if (rd !== 32'h0000_00FF) begin n_fail++; $display("FAIL unmapped_write_ignored: got %h want %h", rd, 32'h0000_00FF); end
        step(1);
        wb_xfer(BASE16 + 32'h100, 32'h0, 4'hF, 1'b1, rd, lat);
        n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL outside_no_ack: got lat %0d want 0", lat); end
        n_checks++; if (io_out16 !== 16'h56A5) begin n_fail++; $display("FAIL outside_state: got %h want %h", io_out16, 16'h56A5); end
        step(1);
    endtask

`ifdef GPIO_BANK_IRQ_EN
    task automatic test_irq();
        io_in16 = 16'h0000;
        step(5);
        wb_xfer(BASE16 + 32'h10, 32'h0000_FFFF, 4'hF, 1'b1, rd, lat); step(1);
        wb_xfer(BASE16 + 32'h0C, 32'h0000_0008, 4'hF, 1'b1, rd, lat); step(1);
        wb_xfer(BASE16 + 32'h14, 32'h0000_0000, 4'hF, 1'b1, rd, lat); step(1);
        wb_xfer(BASE16 + 32'h10, 32'h0, 4'hF, 1'b0, rd, lat);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL stat_cleared: got %h want 0", rd); end
        step(1);
        n_checks++; if (irq16 !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b want 0", irq16); end
        io_in16[3] = 1'b1;
        step(3);
        n_checks++; if (irq16 !== 1'b0) begin n_fail++; $display("FAIL irq_too_early: got %b want 0", irq16); end
        step(1);
        n_checks++; if (irq16 !== 1'b1) begin n_fail++; $display("FAIL irq_after_edge: got %b want 1", irq16); end
        wb_xfer(BASE16 + 32'h10, 32'h0, 4'hF, 1'b0, rd, lat);
        n_checks++; if (rd !== 32'h8) begin n_fail++; $display("FAIL stat_rise3: got %h want %h", rd, 32'h8); end
        step(1);
        wb_xfer(BASE16 + 32'h08, 32'h0, 4'hF, 1'b0, rd, lat);
        n_checks++; if (rd !== 32'h8) begin n_fail++; $display("FAIL in_pin3: got %h want %h", rd, 32'h8); end
        step(1);

        io_in16[3] = 1'b0;
        step(4);
        io_in16[3] = 1'b1;
        step(2);
        wb_xfer(BASE16 + 32'h10, 32'h0000_0008, 4'hF, 1'b1, rd, lat);
        n_checks++; if (irq16 !== 1'b1) begin n_fail++; $display("FAIL race_irq_now: got %b want 1", irq16); end
        step(1);
        n_checks++; if (irq16 !== 1'b1) begin n_fail++; $display("FAIL race_irq_next: got %b want 1", irq16); end
        wb_xfer(BASE16 + 32'h10, 32'h0, 4'hF, 1'b0, rd, lat);
        n_checks++; if (rd !== 32'h8) begin n_fail++; $display("FAIL race_set_wins: got %h want %h", rd, 32'h8); end
        step(1);
        wb_xfer(BASE16 + 32'h10, 32'h0000_0008, 4'hF, 1'b1, rd, lat);
        step(1);
        n_checks++; if (irq16 !== 1'b0) begin n_fail++; $display("FAIL irq_after_w1c: got %b want 0", irq16); end
        wb_xfer(BASE16 + 32'h10, 32'h0, 4'hF, 1'b0, rd, lat);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL stat_after_w1c: got %h want 0", rd); end
        step(1);

        wb_xfer(BASE16 + 32'h14, 32'h0000_0008, 4'hF, 1'b1, rd, lat);
        step(3);
        wb_xfer(BASE16 + 32'h10, 32'h0, 4'hF, 1'b0, rd, lat);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL pol_change_no_edge: got %h want 0", rd); end
        step(1);
        io_in16[3] = 1'b0;
        step(4);
        wb_xfer(BASE16 + 32'h10, 32'h0, 4'hF, 1'b0, rd, lat);
        n_checks++; if (rd !== 32'h8) begin n_fail++; $display("FAIL falling_edge_pol1: got %h want %h", rd, 32'h8); end
        step(1);
    endtask
`else
    task automatic test_irq_disabled();
        wb_xfer(BASE16 + 32'h0C, 32'h0000_FFFF, 4'hF, 1'b1, rd, lat);
        step(1);
        io_in16 = 16'h0000;
        step(4);
        io_in16 = 16'h00FF;
        step(4);
        n_checks++; if (irq16 !== 1'b0) begin n_fail++; $display("FAIL noirq_irq: got %b want 0", irq16); end
        wb_xfer(BASE16 + 32'h10, 32'h0, 4'hF, 1'b0, rd, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL noirq_stat_ack: got lat %0d want 1", lat); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL noirq_stat_read: got %h want 0", rd); end
        step(1);
        wb_xfer(BASE16 + 32'h0C, 32'h0, 4'hF, 1'b0, rd, lat);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL noirq_en_read: got %h want 0", rd); end
        step(1);
    endtask
`endif

    task automatic test_reset_abort();
        io_in16 = 16'hFFFF;
        adr = BASE16; dat_w = 32'h0000_FFFF; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        rst = 1'b1;
        step(1);
        n_checks++; if (bus_ack !== 1'b0) begin n_fail++; $display("FAIL abort_no_ack: got %b want 0", bus_ack); end
        step(1);
        n_checks++; if (bus_ack !== 1'b0) begin n_fail++; $display("FAIL abort_no_ack2: got %b want 0", bus_ack); end
        n_checks++; if (io_oeb16 !== 16'hFFFF) begin n_fail++; $display("FAIL abort_oeb: got %h want %h", io_oeb16, 16'hFFFF); end
        n_checks++; if (io_out16 !== 16'h0000) begin n_fail++; $display("FAIL abort_out: got %h want 0", io_out16); end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst = 1'b0;
        step(6);
        n_checks++; if (irq16 !== 1'b0) begin n_fail++; $display("FAIL abort_irq: got %b want 0", irq16); end
`ifdef GPIO_BANK_IRQ_EN
        wb_xfer(BASE16 + 32'h0C, 32'h0000_FFFF, 4'hF, 1'b1, rd, lat);
        step(2);
        n_checks++; if (irq16 !== 1'b0) begin n_fail++; $display("FAIL fill_irq: got %b want 0", irq16); end
        wb_xfer(BASE16 + 32'h10, 32'h0, 4'hF, 1'b0, rd, lat);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL fill_no_false_edge: got %h want 0", rd); end
        step(1);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_out_write();
        test_in_sync();
        test_back_to_back();
        test_window();
`ifdef GPIO_BANK_IRQ_EN
        test_irq();
`else
        test_irq_disabled();
`endif
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
